// File: rtl/power_unlock_seq_if.sv
// Command/status bundle between the power-unlock PIO register and the lock actuator sequencer.
// master = PIO side (drives cmd), slave = sequencer (drives actuator and status).
interface power_unlock_seq_if;
  logic [7:0] cmd;
  logic       drive_unlock;
  logic       drive_lock;
  logic       unlocked;
  logic       busy;
  logic [7:0] bad_cmd_cnt;

  modport master (
    output cmd,
    input  drive_unlock, drive_lock, unlocked, busy, bad_cmd_cnt
  );

  modport slave (
    input  cmd,
    output drive_unlock, drive_lock, unlocked, busy, bad_cmd_cnt
  );
endinterface

// File: rtl/power_unlock_seq.sv
// Lock actuator sequencer: cmd changes trigger a timed unlock/lock pulse, then cooldown, then settle.
// Define POWER_UNLOCK_AUTO_RELOCK_EN to relock automatically after RELOCK_CYCLES spent in UNLOCKED.
module power_unlock_seq #(
  parameter logic [15:0] PULSE_CYCLES    = 16'd50000,
  parameter logic [15:0] COOLDOWN_CYCLES = 16'd10000,
  parameter logic [31:0] RELOCK_CYCLES   = 32'd50000000,
  parameter logic [7:0]  UNLOCK_CODE     = 8'hA5,
  parameter logic [7:0]  LOCK_CODE       = 8'h5A
) (
  input logic               clk,
  input logic               reset_n,
  power_unlock_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_UNLOCK_PULSE,
    ST_LOCK_PULSE,
    ST_COOLDOWN,
    ST_UNLOCKED
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cmd_q;
  logic        r_armed;
  logic        r_pend_vld, w_pend_vld_nxt;
  logic        r_pend_lock, w_pend_lock_nxt;
  logic        r_target, w_target_nxt;
  logic [15:0] r_pulse_cnt, w_pulse_cnt_nxt;
  logic [15:0] r_cool_cnt, w_cool_cnt_nxt;
  logic [7:0]  r_bad_cnt;
  logic        r_drive_unlock, r_drive_lock, r_unlocked, r_busy;
  logic        w_evt, w_evt_unlock, w_evt_lock, w_evt_bad, w_fresh;
  logic        w_req_unlock, w_req_lock, w_relock_due;

`ifdef POWER_UNLOCK_AUTO_RELOCK_EN
  logic [31:0] r_relock_cnt, w_relock_cnt_nxt;
`endif

  if (PULSE_CYCLES == 16'd0 || COOLDOWN_CYCLES == 16'd0 || RELOCK_CYCLES == 32'd0) begin : g_bad_param
    $error("power_unlock_seq: cycle-count parameters must be non-zero");
  end

  // r_armed holds off event detection for the first edge after reset so a held cmd is not seen as new.
  assign w_evt        = r_armed && (bus.cmd != r_cmd_q);
  assign w_evt_unlock = w_evt && (bus.cmd == UNLOCK_CODE);
  assign w_evt_lock   = w_evt && (bus.cmd == LOCK_CODE);
  assign w_evt_bad    = w_evt && !w_evt_unlock && !w_evt_lock;
  assign w_fresh      = w_evt_unlock || w_evt_lock;
  assign w_req_unlock = w_fresh ? w_evt_unlock : (r_pend_vld && !r_pend_lock);
  assign w_req_lock   = w_fresh ? w_evt_lock   : (r_pend_vld &&  r_pend_lock);

`ifdef POWER_UNLOCK_AUTO_RELOCK_EN
  assign w_relock_due = (r_relock_cnt == 32'd0);
`else
  assign w_relock_due = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_lock_nxt = r_pend_lock;
    w_target_nxt    = r_target;
    w_pulse_cnt_nxt = r_pulse_cnt;
    w_cool_cnt_nxt  = r_cool_cnt;
`ifdef POWER_UNLOCK_AUTO_RELOCK_EN
    w_relock_cnt_nxt = r_relock_cnt;
`endif
    case (r_state)
      ST_LOCKED: begin
        w_pend_vld_nxt = 1'b0;
        if (w_req_unlock) begin
          w_state_nxt     = ST_UNLOCK_PULSE;
          w_target_nxt    = 1'b1;
          w_pulse_cnt_nxt = PULSE_CYCLES - 16'd1;
        end
      end
      ST_UNLOCKED: begin
        w_pend_vld_nxt = 1'b0;
        if (w_req_lock || w_relock_due) begin
          w_state_nxt     = ST_LOCK_PULSE;
          w_target_nxt    = 1'b0;
          w_pulse_cnt_nxt = PULSE_CYCLES - 16'd1;
        end
`ifdef POWER_UNLOCK_AUTO_RELOCK_EN
        else begin
          w_relock_cnt_nxt = r_relock_cnt - 32'd1;
        end
`endif
      end
      ST_UNLOCK_PULSE, ST_LOCK_PULSE: begin
        if (r_pulse_cnt == 16'd0) begin
          w_state_nxt    = ST_COOLDOWN;
          w_cool_cnt_nxt = COOLDOWN_CYCLES - 16'd1;
        end else begin
          w_pulse_cnt_nxt = r_pulse_cnt - 16'd1;
        end
      end
      ST_COOLDOWN: begin
        if (r_cool_cnt == 16'd0) begin
          w_state_nxt = r_target ? ST_UNLOCKED : ST_LOCKED;
`ifdef POWER_UNLOCK_AUTO_RELOCK_EN
          w_relock_cnt_nxt = RELOCK_CYCLES - 32'd1;
`endif
        end else begin
          w_cool_cnt_nxt = r_cool_cnt - 16'd1;
        end
      end
      default: w_state_nxt = ST_LOCKED;
    endcase
    // Valid commands arriving mid-sequence are parked; the latest one wins.
    if ((r_state inside {ST_UNLOCK_PULSE, ST_LOCK_PULSE, ST_COOLDOWN}) && w_fresh) begin
      w_pend_vld_nxt  = 1'b1;
      w_pend_lock_nxt = w_evt_lock;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_LOCKED;
      r_pend_vld     <= 1'b0;
      r_pend_lock    <= 1'b0;
      r_target       <= 1'b0;
      r_pulse_cnt    <= 16'd0;
      r_cool_cnt     <= 16'd0;
      r_drive_unlock <= 1'b0;
      r_drive_lock   <= 1'b0;
      r_unlocked     <= 1'b0;
      r_busy         <= 1'b0;
`ifdef POWER_UNLOCK_AUTO_RELOCK_EN
      r_relock_cnt   <= 32'd0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_pend_vld     <= w_pend_vld_nxt;
      r_pend_lock    <= w_pend_lock_nxt;
      r_target       <= w_target_nxt;
      r_pulse_cnt    <= w_pulse_cnt_nxt;
      r_cool_cnt     <= w_cool_cnt_nxt;
      r_drive_unlock <= (w_state_nxt == ST_UNLOCK_PULSE);
      r_drive_lock   <= (w_state_nxt == ST_LOCK_PULSE);
      r_unlocked     <= (w_state_nxt == ST_UNLOCKED);
      r_busy         <= (w_state_nxt inside {ST_UNLOCK_PULSE, ST_LOCK_PULSE, ST_COOLDOWN});
`ifdef POWER_UNLOCK_AUTO_RELOCK_EN
      r_relock_cnt   <= w_relock_cnt_nxt;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_q   <= 8'h00;
      r_armed   <= 1'b0;
      r_bad_cnt <= 8'h00;
    end else begin
      r_cmd_q <= bus.cmd;
      r_armed <= 1'b1;
      if (w_evt_bad && (r_bad_cnt != 8'hFF)) begin
        r_bad_cnt <= r_bad_cnt + 8'd1;
      end
    end
  end

  assign bus.drive_unlock = r_drive_unlock;
  assign bus.drive_lock   = r_drive_lock;
  assign bus.unlocked     = r_unlocked;
  assign bus.busy         = r_busy;
  assign bus.bad_cmd_cnt  = r_bad_cnt;

endmodule

// File: tb/tb_power_unlock_seq.sv
// Scoreboard bench: a timeline model predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_power_unlock_seq;
  localparam int P = 4;
  localparam int C = 3;
  localparam int R = 20;

  typedef struct packed {
    logic       du;
    logic       dl;
    logic       unl;
    logic       busy;
    logic [7:0] bad;
  } obs_t;

  logic clk;
  logic reset_n;
  power_unlock_seq_if bus ();

  power_unlock_seq #(
    .PULSE_CYCLES    (16'(P)),
    .COOLDOWN_CYCLES (16'(C)),
    .RELOCK_CYCLES   (32'(R)),
    .UNLOCK_CODE     (8'hA5),
    .LOCK_CODE       (8'h5A)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Model: a sequence is described by the cycle its pulse starts and its direction.
  logic [7:0] m_cmd_q;
  bit         m_armed;
  int         m_start;
  bit         m_dir;
  bit         m_unl;
  int         m_pend;
  int         m_unl_since;
  int         m_bad;

  function automatic obs_t dut_obs();
    obs_t a;
    a.du   = bus.drive_unlock;
    a.dl   = bus.drive_lock;
    a.unl  = bus.unlocked;
    a.busy = bus.busy;
    a.bad  = bus.bad_cmd_cnt;
    return a;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got du=%b dl=%b unl=%b busy=%b bad=%h, expected du=%b dl=%b unl=%b busy=%b bad=%h",
               name, cyc, act.du, act.dl, act.unl, act.busy, act.bad,
               exp.du, exp.dl, exp.unl, exp.busy, exp.bad);
    end
  endtask

  task automatic model_reset();
    m_cmd_q = 8'h00; m_armed = 0; m_start = -1; m_dir = 0;
    m_unl = 0; m_pend = 0; m_unl_since = 0; m_bad = 0;
  endtask

  task automatic model_out(output obs_t e);
    if (m_start >= 0 && cyc >= m_start + P + C) begin
      m_unl = m_dir; m_start = -1; m_unl_since = cyc;
    end
    e.busy = (m_start >= 0);
    e.du   = e.busy &&  m_dir && (cyc - m_start < P);
    e.dl   = e.busy && !m_dir && (cyc - m_start < P);
    e.unl  = !e.busy && m_unl;
    e.bad  = 8'(m_bad);
  endtask

  task automatic model_cycle(input logic [7:0] c);
    obs_t e;
    bit   ev, v_unl, v_lck;
    int   req;
    model_out(e);
    sb_q.push_back(e);
    ev    = m_armed && (c != m_cmd_q);
    v_unl = ev && (c == 8'hA5);
    v_lck = ev && (c == 8'h5A);
    if (ev && !v_unl && !v_lck && m_bad < 255) m_bad++;
    if (m_start >= 0) begin
      if (v_unl) m_pend = 1;
      else if (v_lck) m_pend = 2;
    end else begin
      req = v_unl ? 1 : (v_lck ? 2 : m_pend);
      m_pend = 0;
      if (req == 1 && !m_unl) begin
        m_start = cyc + 1; m_dir = 1;
      end else if (req == 2 && m_unl) begin
        m_start = cyc + 1; m_dir = 0;
      end
`ifdef POWER_UNLOCK_AUTO_RELOCK_EN
      else if (m_unl && (cyc - m_unl_since + 1 >= R)) begin
        m_start = cyc + 1; m_dir = 0;
      end
`endif
    end
    m_cmd_q = c;
    m_armed = 1;
  endtask

  task automatic step(input logic [7:0] c);
    @(posedge clk);
    #1;
    bus.cmd = c;
    cyc++;
    model_cycle(c);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(bus.cmd);
  endtask

  task automatic reset_dut(input logic [7:0] c);
    obs_t e;
    obs_t zero;
    zero = '0;
    @(posedge clk);
    #1;
    cyc++;
    if (reset_n === 1'b1) begin
      model_out(e);
      check("pre_reset_drive", dut_obs(), e);
    end
    bus.cmd = c;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("reset_outputs", dut_obs(), zero);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc++;
    model_cycle(c);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && sb_q.size() != 0) begin
      obs_t e;
      e = sb_q.pop_front();
      check("scoreboard", dut_obs(), e);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.cmd = 8'h00;
    model_reset();

    // Basic unlock then lock.
    reset_dut(8'h00);
    hold(3);
    step(8'hA5);
    hold(10);
    step(8'h5A);
    hold(10);

    // Lock requested during unlock cooldown runs right after UNLOCKED is entered.
    step(8'hA5);
    hold(5);
    step(8'h5A);
    hold(14);

    // Newer pending command overwrites older one: pending unlock is then ignored in UNLOCKED.
    step(8'hA5);
    step(8'h5A);
    step(8'hA5);
    hold(10);
    step(8'h5A);
    hold(10);

    // Randomized command stream, including changes while busy.
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)       step(8'hA5);
      else if (sel < 8)  step(8'h5A);
      else if (sel == 8) step(8'h00);
      else               step(8'($urandom_range(0, 255)));
      hold($urandom_range(0, 9));
    end
    hold(12);

    // Invalid-command counter saturation, no actuator drive.
    reset_dut(8'h00);
    for (int i = 0; i < 260; i++) step((i % 2 == 0) ? 8'h11 : 8'h22);
    hold(3);

    // Long dwell in UNLOCKED (auto-relock when enabled).
    reset_dut(8'h00);
    step(8'h00);
    step(8'hA5);
    hold(1010);

    // Reset mid-pulse with cmd held: drive drops at once and no event after release.
    reset_dut(8'h00);
    step(8'h00);
    step(8'hA5);
    step(8'hA5);
    reset_dut(8'hA5);
    hold(12);

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/power_unlock_seq.md
POWER_UNLOCK_SEQ -- requirements
Module: power_unlock_seq

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 16'd50000, actuator drive pulse length in clk cycles (legal range 1..65535).
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 16'd10000, post-pulse dead time in clk cycles (legal range 1..65535).
REQ-003 SHALL have parameter RELOCK_CYCLES, default 32'd50000000, auto-relock timeout in clk cycles (legal range 1..2^32-1).
REQ-004 SHALL have parameter UNLOCK_CODE, default 8'hA5, command value that requests unlock.
REQ-005 SHALL have parameter LOCK_CODE, default 8'h5A, command value that requests lock.
REQ-006 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port cmd, input, 8, command byte from the power-unlock PIO out_port, same clock domain, registered upstream.
REQ-009 SHALL have port drive_unlock, output, 1, unlock actuator drive.
REQ-010 SHALL have port drive_lock, output, 1, lock actuator drive.
REQ-011 SHALL have port unlocked, output, 1, settled status: 1 = unlocked.
REQ-012 SHALL have port busy, output, 1, 1 while in UNLOCK_PULSE, LOCK_PULSE or COOLDOWN.
REQ-013 SHALL have port bad_cmd_cnt, output, 8, saturating count of invalid commands.

Function
REQ-014 SHALL register cmd into cmd_q every cycle; a command event is any cycle with cmd != cmd_q.
REQ-015 SHALL classify an event as UNLOCK (cmd==UNLOCK_CODE), LOCK (cmd==LOCK_CODE) or invalid (any other value, including 8'h00).
REQ-016 SHALL increment bad_cmd_cnt by 1 on each invalid event, saturating at 8'hFF.
REQ-017 SHALL implement FSM states LOCKED, UNLOCK_PULSE, LOCK_PULSE, COOLDOWN and UNLOCKED.
REQ-018 SHALL go LOCKED->UNLOCK_PULSE on an UNLOCK event and UNLOCKED->LOCK_PULSE on a LOCK event; UNLOCK in UNLOCKED and LOCK in LOCKED SHALL be ignored, with no pulse and no pending entry.
REQ-019 SHALL assert drive_unlock (or drive_lock) starting the cycle after the event, for exactly PULSE_CYCLES cycles; both SHALL never be high together.
REQ-020 SHALL go from a pulse state to COOLDOWN for exactly COOLDOWN_CYCLES cycles, then to UNLOCKED (after unlock pulse) or LOCKED (after lock pulse), held in a 1-bit target register.
REQ-021 SHALL drive unlocked=1 only in state UNLOCKED; during pulse and cooldown it SHALL be 0.
REQ-022 SHALL store a valid event arriving while busy in a 1-entry pending register; a newer valid event SHALL overwrite the stored one.
REQ-023 SHALL consume the pending entry in the first cycle of LOCKED/UNLOCKED, applying REQ-018 as if it were a fresh event; a fresh event in that same cycle SHALL take priority and clear the pending entry.
REQ-024 SHALL use 16-bit down-counters for pulse and cooldown, reloaded on each state entry.

Reset
REQ-025 SHALL, on reset_n low, asynchronously set state=LOCKED, cmd_q=8'h00, pending empty, all counters 0, bad_cmd_cnt=0, drive_unlock=0, drive_lock=0, unlocked=0, busy=0.
REQ-026 SHALL, on reset asserted mid-pulse, drop the drive output the same instant (asynchronously) with no cooldown; the first clk edge after release SHALL sample cmd into cmd_q without generating an event.

Configuration
REQ-027 SHALL, with macro POWER_UNLOCK_AUTO_RELOCK_EN defined, run a 32-bit counter in UNLOCKED that reloads on entry and, after RELOCK_CYCLES cycles with no LOCK event, enters LOCK_PULSE as if a LOCK event had occurred.
REQ-028 SHALL, without POWER_UNLOCK_AUTO_RELOCK_EN, omit the relock counter entirely; UNLOCKED is left only on a LOCK event or reset.

Verification (PULSE_CYCLES=4, COOLDOWN_CYCLES=3, RELOCK_CYCLES=20)
REQ-029 SHALL cover: reset, cmd 00->A5 at cycle n -> drive_unlock high n+1..n+4, busy high n+1..n+7, unlocked=1 from n+8.
REQ-030 SHALL cover: while unlocked, cmd A5->5A -> drive_lock high for 4 cycles, then unlocked=0, state LOCKED after 3 cooldown cycles.
REQ-031 SHALL cover: cmd 00->A5, then 5A during cooldown -> unlock completes, then lock pulse begins the cycle after entering UNLOCKED.
REQ-032 SHALL cover: cmd toggled through 260 invalid values -> bad_cmd_cnt saturates at 8'hFF and no drive output asserts.
REQ-033 SHALL cover: with POWER_UNLOCK_AUTO_RELOCK_EN, after unlock and no further cmd -> drive_lock asserts 20 cycles after UNLOCKED entry; without the macro, unlocked stays 1 for at least 1000 cycles.
REQ-034 SHALL cover: reset_n pulsed low at pulse cycle 2 -> drive_unlock falls immediately and no event follows release with cmd held at A5.
